// File: rtl/memory_arbiter.sv
// Two-port arbiter sharing one line-wide Memory port between the instruction and data caches.
// Round-robin on ties, one transaction at a time, Memory handshake mirrored on each cache port.
module memory_arbiter #(
    parameter int ADDRESS_SIZE    = 32,
    parameter int CACHE_LINE_SIZE = 128,
    parameter int TIMEOUT_CYCLES  = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       inst_op_init,
    input  logic [ADDRESS_SIZE-1:0]    inst_address,
    output logic [CACHE_LINE_SIZE-1:0] inst_data_out,
    output logic                       inst_data_ready,
    output logic                       inst_memory_in_use,
    input  logic                       data_op_init,
    input  logic                       data_op,
    input  logic [ADDRESS_SIZE-1:0]    data_address,
    input  logic [CACHE_LINE_SIZE-1:0] data_data_in,
    output logic [CACHE_LINE_SIZE-1:0] data_data_out,
    output logic                       data_data_ready,
    output logic                       data_memory_in_use,
    output logic                       mem_op_init,
    output logic                       mem_op,
    output logic [ADDRESS_SIZE-1:0]    mem_address,
    output logic [CACHE_LINE_SIZE-1:0] mem_data_in,
    output logic                       mem_op_done,
    input  logic [CACHE_LINE_SIZE-1:0] mem_data_out,
    input  logic                       mem_data_ready,
    input  logic                       mem_memory_in_use,
    output logic                       timeout_error
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic        GNT_INST      = 1'b0;
    localparam logic        GNT_DATA      = 1'b1;
    localparam logic [31:0] TIMEOUT_LIMIT = 32'(TIMEOUT_CYCLES);

    state_t      state;
    state_t      state_next;
    logic        grant;
    logic        last_grant;
    logic        winner;
    logic        grant_fire;
    logic        complete;
    logic        granted_req;
    logic        busy;
    logic [31:0] wait_cnt;

    // Arbitration and completion decode
    always_comb begin
        winner = GNT_INST;
        if (inst_op_init && data_op_init) begin
            winner = ~last_grant;
        end else if (data_op_init) begin
            winner = GNT_DATA;
        end
        grant_fire  = (state == IDLE) && (inst_op_init || data_op_init) && !mem_memory_in_use;
        complete    = ((state == ISSUE) || (state == WAIT)) && mem_data_ready;
        granted_req = (grant == GNT_DATA) ? data_op_init : inst_op_init;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_fire) state_next = ISSUE;
            ISSUE:   state_next = complete ? DONE : WAIT;
            WAIT:    if (complete) state_next = DONE;
            // Hold here until the served cache lowers its request, so a held request is not served twice
            DONE:    if (!granted_req) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy               = (state != IDLE);
        mem_op_init        = (state == ISSUE);
        inst_memory_in_use = busy ? (grant != GNT_INST) : mem_memory_in_use;
        data_memory_in_use = busy ? (grant != GNT_DATA) : mem_memory_in_use;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            grant           <= GNT_INST;
            last_grant      <= GNT_INST;
            inst_data_ready <= 1'b0;
            data_data_ready <= 1'b0;
            mem_op_done     <= 1'b0;
            wait_cnt        <= '0;
            timeout_error   <= 1'b0;
        end else begin
            state           <= state_next;
            inst_data_ready <= complete && (grant == GNT_INST);
            data_data_ready <= complete && (grant == GNT_DATA);
            mem_op_done     <= complete;
            if (grant_fire) begin
                grant      <= winner;
                last_grant <= winner;
                wait_cnt   <= '0;
            end else if ((state == WAIT) && (wait_cnt != TIMEOUT_LIMIT)) begin
                wait_cnt <= wait_cnt + 32'd1;
            end
            // Watchdog only flags; the transaction keeps waiting for Memory
            if ((TIMEOUT_CYCLES > 0) && (state == WAIT) && (wait_cnt + 32'd1 >= TIMEOUT_LIMIT)) begin
                timeout_error <= 1'b1;
            end
        end
    end

    // Grant-edge latch of the request and completion capture of the returned line
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_op        <= 1'b0;
            mem_address   <= '0;
            mem_data_in   <= '0;
            inst_data_out <= '0;
            data_data_out <= '0;
        end else begin
            if (grant_fire) begin
                mem_address <= (winner == GNT_DATA) ? data_address : inst_address;
                mem_op      <= (winner == GNT_DATA) ? data_op : 1'b0;
                if (winner == GNT_DATA) begin
                    mem_data_in <= data_data_in;
                end
            end
            if (complete && (grant == GNT_INST)) begin
                inst_data_out <= mem_data_out;
            end
            if (complete && (grant == GNT_DATA) && !mem_op) begin
                data_data_out <= mem_data_out;
            end
        end
    end

endmodule
